// File: rtl/geri_yazma_kuyrugu_pkg.sv
// Shared definitions for the writeback queue: register-address width,
// default depth, the queue entry type and a small address helper.
`ifndef GERI_YAZMA_KUYRUGU_TANIM
`define GERI_YAZMA_KUYRUGU_TANIM
`define HY_BIT 5
`define GYK_DERINLIK 4
`endif

package geri_yazma_kuyrugu_pkg;

   localparam int HY_W   = `HY_BIT;
   localparam int VERI_W = 32;

   // One pending register-file write
   typedef struct packed {
      logic [HY_W-1:0]   adres;
      logic [VERI_W-1:0] deger;
   } gy_giris_t;

   // x0 is hard-wired to zero, so it is never queued and never forwarded
   function automatic logic adres_gecerli(input logic [HY_W-1:0] adres);
      return (adres != {HY_W{1'b0}});
   endfunction

endpackage

// File: rtl/geri_yazma_kuyrugu_yonlendirme_arama.sv
// Youngest-match search over the occupied queue entries for one read port.
module yonlendirme_arama
   import geri_yazma_kuyrugu_pkg::*;
#(
   parameter int DERINLIK = `GYK_DERINLIK,
   localparam int PW      = $clog2(DERINLIK)
) (
   input  gy_giris_t [DERINLIK-1:0] girisler_g,
   input  logic [PW-1:0]            bas_g,
   input  logic [PW:0]              doluluk_g,
   input  logic [HY_W-1:0]          ky_adres_g,
   output logic                     yonlendir_c,
   output logic [VERI_W-1:0]        yonlendir_deger_c
);

   logic              bulundu_s;
   logic [VERI_W-1:0] deger_s;
   logic [PW-1:0]     sira_s;
   logic              eslesme_s;

   // Walk entries oldest to youngest so a later match overrides an earlier one
   always_comb begin
      bulundu_s = 1'b0;
      deger_s   = {VERI_W{1'b0}};
      sira_s    = {PW{1'b0}};
      eslesme_s = 1'b0;
      for (int i = 0; i < DERINLIK; i++) begin
         sira_s    = bas_g + PW'(i);
         eslesme_s = ((PW+1)'(i) < doluluk_g) &&
                     adres_gecerli(ky_adres_g) &&
                     (girisler_g[sira_s].adres == ky_adres_g);
         bulundu_s = bulundu_s | eslesme_s;
         deger_s   = eslesme_s ? girisler_g[sira_s].deger : deger_s;
      end
   end

   assign yonlendir_c       = bulundu_s;
   assign yonlendir_deger_c = deger_s;

endmodule

// File: rtl/geri_yazma_kuyrugu.sv
// Writeback queue: accepts results from the memory unit and the ALU,
// drains one write per cycle to the register file, and forwards the
// youngest pending value for two lookup addresses.
module geri_yazma_kuyrugu
   import geri_yazma_kuyrugu_pkg::*;
#(
   parameter int DERINLIK = `GYK_DERINLIK
) (
   input  logic                clk_g,
   input  logic                rst_g,
   input  logic                bel_gecerli_g,
   input  logic [`HY_BIT-1:0]  bel_adres_g,
   input  logic [31:0]         bel_deger_g,
   output logic                bel_hazir_c,
   input  logic                alu_gecerli_g,
   input  logic [`HY_BIT-1:0]  alu_adres_g,
   input  logic [31:0]         alu_deger_g,
   output logic                alu_hazir_c,
   output logic [`HY_BIT-1:0]  hy_adres_c,
   output logic [31:0]         hy_deger_c,
   output logic                yaz_c,
   input  logic [`HY_BIT-1:0]  ky1_adres_g,
   input  logic [`HY_BIT-1:0]  ky2_adres_g,
   output logic                ky1_yonlendir_c,
   output logic [31:0]         ky1_yonlendir_deger_c,
   output logic                ky2_yonlendir_c,
   output logic [31:0]         ky2_yonlendir_deger_c
);

   localparam int PW = $clog2(DERINLIK);

   gy_giris_t [DERINLIK-1:0] kuyruk_r;
   logic [PW-1:0]            bas_r;
   logic [PW-1:0]            son_r;
   logic [PW:0]              doluluk_r;

   logic [PW:0]   bos_s;
   logic          bel_hazir_s;
   logic          alu_hazir_s;
   logic          bel_yaz_s;
   logic          alu_yaz_s;
   logic          cik_s;
   logic [1:0]    giren_s;
   logic [PW-1:0] alu_yer_s;

   // Readiness from current occupancy only, and which transfers really enqueue
   always_comb begin
      bos_s       = (PW+1)'(DERINLIK) - doluluk_r;
      bel_hazir_s = (bos_s >= (PW+1)'(1));
      alu_hazir_s = bel_gecerli_g ? (bos_s >= (PW+1)'(2)) : (bos_s >= (PW+1)'(1));
      bel_yaz_s   = !rst_g && bel_gecerli_g && bel_hazir_s && adres_gecerli(bel_adres_g);
      alu_yaz_s   = !rst_g && alu_gecerli_g && alu_hazir_s && adres_gecerli(alu_adres_g);
      cik_s       = (doluluk_r != {(PW+1){1'b0}});
      giren_s     = {1'b0, bel_yaz_s} + {1'b0, alu_yaz_s};
      // The ALU entry lands behind the memory-unit entry when both enqueue
      alu_yer_s   = son_r + PW'(bel_yaz_s);
   end

   // Pointer and occupancy update; the head always drains when present
   always_ff @(posedge clk_g) begin
      if (rst_g) begin
         bas_r     <= {PW{1'b0}};
         son_r     <= {PW{1'b0}};
         doluluk_r <= {(PW+1){1'b0}};
      end else begin
         bas_r     <= bas_r + PW'(cik_s);
         son_r     <= son_r + PW'(giren_s);
         doluluk_r <= doluluk_r + (PW+1)'(giren_s) - (PW+1)'(cik_s);
      end
   end

   // Entry storage; contents are qualified by occupancy so no reset is needed
   always_ff @(posedge clk_g) begin
      if (bel_yaz_s) begin
         kuyruk_r[son_r] <= '{adres: bel_adres_g, deger: bel_deger_g};
      end
      if (alu_yaz_s) begin
         kuyruk_r[alu_yer_s] <= '{adres: alu_adres_g, deger: alu_deger_g};
      end
   end

   assign bel_hazir_c = bel_hazir_s;
   assign alu_hazir_c = alu_hazir_s;
   assign yaz_c       = cik_s;
   assign hy_adres_c  = kuyruk_r[bas_r].adres;
   assign hy_deger_c  = kuyruk_r[bas_r].deger;

   yonlendirme_arama #(.DERINLIK(DERINLIK)) u_arama1 (
      .girisler_g        (kuyruk_r),
      .bas_g             (bas_r),
      .doluluk_g         (doluluk_r),
      .ky_adres_g        (ky1_adres_g),
      .yonlendir_c       (ky1_yonlendir_c),
      .yonlendir_deger_c (ky1_yonlendir_deger_c)
   );

   yonlendirme_arama #(.DERINLIK(DERINLIK)) u_arama2 (
      .girisler_g        (kuyruk_r),
      .bas_g             (bas_r),
      .doluluk_g         (doluluk_r),
      .ky_adres_g        (ky2_adres_g),
      .yonlendir_c       (ky2_yonlendir_c),
      .yonlendir_deger_c (ky2_yonlendir_deger_c)
   );

endmodule

// File: tb/tb_geri_yazma_kuyrugu.sv
// Self-checking bench for geri_yazma_kuyrugu with a queue-based reference model.
module tb_geri_yazma_kuyrugu;

   localparam int D = 4;

   logic        clk_g = 1'b0;
   logic        rst_g;
   logic        bel_gecerli_g, alu_gecerli_g;
   logic [4:0]  bel_adres_g, alu_adres_g, ky1_adres_g, ky2_adres_g;
   logic [31:0] bel_deger_g, alu_deger_g;
   logic        bel_hazir_c, alu_hazir_c, yaz_c;
   logic [4:0]  hy_adres_c;
   logic [31:0] hy_deger_c;
   logic        ky1_yonlendir_c, ky2_yonlendir_c;
   logic [31:0] ky1_yonlendir_deger_c, ky2_yonlendir_deger_c;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } giris_t;

   giris_t q[$];
   int kontrol = 0;
   int hata    = 0;

   logic        e_bel_h, e_alu_h, e_yaz, e_y1, e_y2;
   logic [4:0]  e_adr;
   logic [31:0] e_deg, e_yd1, e_yd2;

   geri_yazma_kuyrugu #(.DERINLIK(D)) dut (
      .clk_g                 (clk_g),
      .rst_g                 (rst_g),
      .bel_gecerli_g         (bel_gecerli_g),
      .bel_adres_g           (bel_adres_g),
      .bel_deger_g           (bel_deger_g),
      .bel_hazir_c           (bel_hazir_c),
      .alu_gecerli_g         (alu_gecerli_g),
      .alu_adres_g           (alu_adres_g),
      .alu_deger_g           (alu_deger_g),
      .alu_hazir_c           (alu_hazir_c),
      .hy_adres_c            (hy_adres_c),
      .hy_deger_c            (hy_deger_c),
      .yaz_c                 (yaz_c),
      .ky1_adres_g           (ky1_adres_g),
      .ky2_adres_g           (ky2_adres_g),
      .ky1_yonlendir_c       (ky1_yonlendir_c),
      .ky1_yonlendir_deger_c (ky1_yonlendir_deger_c),
      .ky2_yonlendir_c       (ky2_yonlendir_c),
      .ky2_yonlendir_deger_c (ky2_yonlendir_deger_c)
   );

   always #5 clk_g = ~clk_g;

   // Youngest pending value for an address; x0 never hits
   function automatic void ara(input logic [4:0] k, output logic h, output logic [31:0] v);
      h = 1'b0;
      v = 32'h0;
      if (k != 5'd0) begin
         foreach (q[i]) begin
            if (q[i].a == k) begin
               h = 1'b1;
               v = q[i].d;
            end
         end
      end
   endfunction

   function automatic void beklenen_hesapla();
      int bos;
      bos     = D - q.size();
      e_bel_h = (bos >= 1);
      e_alu_h = bel_gecerli_g ? (bos >= 2) : (bos >= 1);
      e_yaz   = (q.size() != 0);
      e_adr   = e_yaz ? q[0].a : 5'd0;
      e_deg   = e_yaz ? q[0].d : 32'h0;
      ara(ky1_adres_g, e_y1, e_yd1);
      ara(ky2_adres_g, e_y2, e_yd2);
   endfunction

   // Drive one cycle of inputs at the falling edge and compute expectations
   task automatic uygula(input logic r, input logic bg, input logic [4:0] ba, input logic [31:0] bd,
                         input logic ag, input logic [4:0] aa, input logic [31:0] ad,
                         input logic [4:0] k1, input logic [4:0] k2);
      @(negedge clk_g);
      rst_g = r;
      bel_gecerli_g = bg; bel_adres_g = ba; bel_deger_g = bd;
      alu_gecerli_g = ag; alu_adres_g = aa; alu_deger_g = ad;
      ky1_adres_g = k1; ky2_adres_g = k2;
      #1;
      beklenen_hesapla();
   endtask

   // Advance the model across the rising edge
   task automatic kenar();
      int  bos;
      bit  bh, ah;
      @(posedge clk_g);
      bos = D - q.size();
      bh  = (bos >= 1);
      ah  = bel_gecerli_g ? (bos >= 2) : (bos >= 1);
      if (rst_g) begin
         q.delete();
      end else begin
         if (q.size() > 0) void'(q.pop_front());
         if (bel_gecerli_g && bh && bel_adres_g != 5'd0) q.push_back('{a: bel_adres_g, d: bel_deger_g});
         if (alu_gecerli_g && ah && alu_adres_g != 5'd0) q.push_back('{a: alu_adres_g, d: alu_deger_g});
      end
   endtask

   task automatic test_reset();
      uygula(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0); kenar();
      uygula(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0); kenar();
      uygula(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
      kontrol++; if (yaz_c !== 1'b0) begin hata++; $display("FAIL reset_yaz actual=%0h expected=0", yaz_c); end
      kontrol++; if (ky1_yonlendir_c !== 1'b0 || ky1_yonlendir_deger_c !== 32'h0) begin hata++; $display("FAIL reset_yon actual=%0h/%0h expected=0/0", ky1_yonlendir_c, ky1_yonlendir_deger_c); end
      kontrol++; if (bel_hazir_c !== 1'b1 || alu_hazir_c !== 1'b1) begin hata++; $display("FAIL reset_hazir actual=%0h/%0h expected=1/1", bel_hazir_c, alu_hazir_c); end
      kenar();
   endtask

   task automatic test_tek_yazma();
      uygula(1'b0, 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      kontrol++; if (bel_hazir_c !== 1'b1) begin hata++; $display("FAIL tek_hazir actual=%0h expected=1", bel_hazir_c); end
      kenar();
      uygula(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      kontrol++; if (yaz_c !== 1'b1 || hy_adres_c !== 5'd5 || hy_deger_c !== 32'h11) begin hata++; $display("FAIL tek_yazma actual=%0h/%0h/%0h expected=1/5/11", yaz_c, hy_adres_c, hy_deger_c); end
      kenar();
      uygula(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      kontrol++; if (yaz_c !== 1'b0) begin hata++; $display("FAIL tek_bosalma actual=%0h expected=0", yaz_c); end
      kenar();
   endtask

   task automatic test_cift_uretici();
      uygula(1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, 5'd3, 5'd0);
      kontrol++; if (bel_hazir_c !== 1'b1 || alu_hazir_c !== 1'b1) begin hata++; $display("FAIL cift_hazir actual=%0h/%0h expected=1/1", bel_hazir_c, alu_hazir_c); end
      kontrol++; if (ky1_yonlendir_c !== 1'b0) begin hata++; $display("FAIL cift_bos_arama actual=%0h expected=0", ky1_yonlendir_c); end
      kenar();
      uygula(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
      kontrol++; if (yaz_c !== 1'b1 || hy_adres_c !== 5'd3 || hy_deger_c !== 32'hA) begin hata++; $display("FAIL cift_ilk actual=%0h/%0h/%0h expected=1/3/a", yaz_c, hy_adres_c, hy_deger_c); end
      kontrol++; if (ky1_yonlendir_c !== 1'b1 || ky1_yonlendir_deger_c !== 32'hB) begin hata++; $display("FAIL cift_genc actual=%0h/%0h expected=1/b", ky1_yonlendir_c, ky1_yonlendir_deger_c); end
      kenar();
      uygula(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
      kontrol++; if (yaz_c !== 1'b1 || hy_adres_c !== 5'd3 || hy_deger_c !== 32'hB) begin hata++; $display("FAIL cift_ikinci actual=%0h/%0h/%0h expected=1/3/b", yaz_c, hy_adres_c, hy_deger_c); end
      kenar();
      uygula(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
      kontrol++; if (yaz_c !== 1'b0 || ky1_yonlendir_c !== 1'b0) begin hata++; $display("FAIL cift_son actual=%0h/%0h expected=0/0", yaz_c, ky1_yonlendir_c); end
      kenar();
   endtask

   task automatic test_dolu();
      for (int i = 0; i < 6; i++) begin
         uygula(1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom, 5'd0, 5'd0);
         kontrol++; if (bel_hazir_c !== e_bel_h || alu_hazir_c !== e_alu_h) begin hata++; $display("FAIL dolu_hazir actual=%0h/%0h expected=%0h/%0h", bel_hazir_c, alu_hazir_c, e_bel_h, e_alu_h); end
         if (i == 2) begin
            kontrol++; if (bel_hazir_c !== 1'b1 || alu_hazir_c !== 1'b0) begin hata++; $display("FAIL uc_giris_hazir actual=%0h/%0h expected=1/0", bel_hazir_c, alu_hazir_c); end
         end
         kenar();
      end
      for (int i = 0; i < 5; i++) begin
         uygula(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
         kontrol++; if (yaz_c !== e_yaz || (e_yaz && (hy_adres_c !== e_adr || hy_deger_c !== e_deg))) begin hata++; $display("FAIL dolu_bosalt actual=%0h/%0h/%0h expected=%0h/%0h/%0h", yaz_c, hy_adres_c, hy_deger_c, e_yaz, e_adr, e_deg); end
         kenar();
      end
   endtask

   task automatic test_sifir_adres();
      uygula(1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      kontrol++; if (bel_hazir_c !== 1'b1) begin hata++; $display("FAIL x0_hazir actual=%0h expected=1", bel_hazir_c); end
      kenar();
      uygula(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      kontrol++; if (yaz_c !== 1'b0 || ky1_yonlendir_c !== 1'b0 || ky1_yonlendir_deger_c !== 32'h0) begin hata++; $display("FAIL x0_yazma actual=%0h/%0h/%0h expected=0/0/0", yaz_c, ky1_yonlendir_c, ky1_yonlendir_deger_c); end
      kenar();
   endtask

   task automatic test_reset_ortasi();
      logic [31:0] veri [10];
      uygula(1'b0, 1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h102, 5'd0, 5'd0); kenar();
      uygula(1'b0, 1'b1, 5'd3, 32'h103, 1'b1, 5'd4, 32'h104, 5'd0, 5'd0); kenar();
      uygula(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd3);
      kontrol++; if (yaz_c !== 1'b1) begin hata++; $display("FAIL reset_oncesi actual=%0h expected=1", yaz_c); end
      kenar();
      for (int i = 0; i < 3; i++) begin
         uygula(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd3);
         kontrol++; if (yaz_c !== 1'b0 || ky1_yonlendir_c !== 1'b0 || ky2_yonlendir_c !== 1'b0) begin hata++; $display("FAIL reset_sonrasi actual=%0h/%0h/%0h expected=0/0/0", yaz_c, ky1_yonlendir_c, ky2_yonlendir_c); end
         kenar();
      end
      for (int i = 0; i < 10; i++) begin
         veri[i] = $urandom;
         uygula(1'b0, 1'b1, 5'(i + 1), veri[i], 1'b0, 5'd0, 32'h0, 5'(i), 5'd0);
         if (i > 0) begin
            kontrol++; if (yaz_c !== 1'b1 || hy_adres_c !== 5'(i) || hy_deger_c !== veri[i-1]) begin hata++; $display("FAIL sarma_%0d actual=%0h/%0h/%0h expected=1/%0h/%0h", i, yaz_c, hy_adres_c, hy_deger_c, i, veri[i-1]); end
            kontrol++; if (ky1_yonlendir_c !== 1'b1 || ky1_yonlendir_deger_c !== veri[i-1]) begin hata++; $display("FAIL sarma_arama_%0d actual=%0h/%0h expected=1/%0h", i, ky1_yonlendir_c, ky1_yonlendir_deger_c, veri[i-1]); end
         end
         kenar();
      end
      uygula(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      kontrol++; if (yaz_c !== 1'b1 || hy_adres_c !== 5'd10 || hy_deger_c !== veri[9]) begin hata++; $display("FAIL sarma_son actual=%0h/%0h/%0h expected=1/a/%0h", yaz_c, hy_adres_c, hy_deger_c, veri[9]); end
      kenar();
      uygula(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0); kenar();
   endtask

   task automatic test_rastgele();
      for (int i = 0; i < 400; i++) begin
         uygula(($urandom_range(0, 49) == 0), 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         kontrol++; if (bel_hazir_c !== e_bel_h) begin hata++; $display("FAIL r_bel_hazir i=%0d actual=%0h expected=%0h", i, bel_hazir_c, e_bel_h); end
         kontrol++; if (alu_hazir_c !== e_alu_h) begin hata++; $display("FAIL r_alu_hazir i=%0d actual=%0h expected=%0h", i, alu_hazir_c, e_alu_h); end
         kontrol++; if (yaz_c !== e_yaz) begin hata++; $display("FAIL r_yaz i=%0d actual=%0h expected=%0h", i, yaz_c, e_yaz); end
         if (e_yaz) begin
            kontrol++; if (hy_adres_c !== e_adr || hy_deger_c !== e_deg) begin hata++; $display("FAIL r_bas i=%0d actual=%0h/%0h expected=%0h/%0h", i, hy_adres_c, hy_deger_c, e_adr, e_deg); end
         end
         kontrol++; if (ky1_yonlendir_c !== e_y1 || ky1_yonlendir_deger_c !== e_yd1) begin hata++; $display("FAIL r_ky1 i=%0d actual=%0h/%0h expected=%0h/%0h", i, ky1_yonlendir_c, ky1_yonlendir_deger_c, e_y1, e_yd1); end
         kontrol++; if (ky2_yonlendir_c !== e_y2 || ky2_yonlendir_deger_c !== e_yd2) begin hata++; $display("FAIL r_ky2 i=%0d actual=%0h/%0h expected=%0h/%0h", i, ky2_yonlendir_c, ky2_yonlendir_deger_c, e_y2, e_yd2); end
         kenar();
      end
   endtask

   initial begin
      rst_g = 1'b1;
      bel_gecerli_g = 1'b0; bel_adres_g = 5'd0; bel_deger_g = 32'h0;
      alu_gecerli_g = 1'b0; alu_adres_g = 5'd0; alu_deger_g = 32'h0;
      ky1_adres_g = 5'd0; ky2_adres_g = 5'd0;
      test_reset();
      test_tek_yazma();
      test_cift_uretici();
      test_dolu();
      test_sifir_adres();
      test_reset_ortasi();
      test_rastgele();
      $display("TB_RESULT checks=%0d failures=%0d", kontrol, hata);
      $finish;
   end

endmodule
